// File: rtl/block_fetch_pp_pkg.sv
// Shared state and plane encodings for the block fetch stage, plus the sample widening helper.
package block_fetch_pp_pkg;

  typedef enum logic [1:0] {
    S_BF_IDLE  = 2'd0,
    S_BF_ISSUE = 2'd1,
    S_BF_DRAIN = 2'd2
  } bf_state_type;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  function automatic logic [31:0] widen_sample(input logic [15:0] s, input logic sign_ext);
    return sign_ext ? {{16{s[15]}}, s} : {16'h0000, s};
  endfunction

endpackage

// File: rtl/bf_addr_gen.sv
// Plane/row/col block counters and the SRAM read address for sample index k of the current block.
module bf_addr_gen
  import block_fetch_pp_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int BLK_LOG2 = 3,
  parameter int Y_BASE   = 76800,
  parameter int U_BASE   = 153600,
  parameter int V_BASE   = 192000,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 6
) (
  input  logic                  CLOCK_50_I,
  input  logic                  Resetn,
  input  logic                  advance,
  input  logic                  restart,
  input  logic [2*BLK_LOG2-1:0] sample_idx,
  output logic [1:0]            plane,
  output logic [ROW_W-1:0]      row_blk,
  output logic [COL_W-1:0]      col_blk,
  output logic                  last_block,
  output logic [17:0]           sram_address
);

  localparam int B = 1 << BLK_LOG2;
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H / B - 1);
  localparam logic [COL_W-1:0] COL_LAST_Y = COL_W'(IMG_W / B - 1);
  localparam logic [COL_W-1:0] COL_LAST_C = COL_W'(IMG_W / (2 * B) - 1);

  logic [COL_W-1:0]    col_last;
  logic [17:0]         base;
  logic [17:0]         stride;
  logic [BLK_LOG2-1:0] r;
  logic [BLK_LOG2-1:0] c;

  // row_blk*B + r and col_blk*B + c are plain concatenations since B is a power of two
  always_comb begin
    r        = sample_idx[2*BLK_LOG2-1:BLK_LOG2];
    c        = sample_idx[BLK_LOG2-1:0];
    col_last = (plane == PLANE_Y) ? COL_LAST_Y : COL_LAST_C;
    case (plane)
      PLANE_U: base = 18'(U_BASE);
      PLANE_V: base = 18'(V_BASE);
      default: base = 18'(Y_BASE);
    endcase
    stride       = (plane == PLANE_Y) ? 18'(IMG_W) : 18'(IMG_W / 2);
    sram_address = base + 18'({row_blk, r}) * stride + 18'({col_blk, c});
    last_block   = (plane == PLANE_V) && (row_blk == ROW_LAST) && (col_blk == col_last);
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      plane   <= PLANE_Y;
      row_blk <= '0;
      col_blk <= '0;
    end else if (restart) begin
      plane   <= PLANE_Y;
      row_blk <= '0;
      col_blk <= '0;
    end else if (advance) begin
      if (col_blk != col_last) begin
        col_blk <= col_blk + COL_W'(1);
      end else begin
        col_blk <= '0;
        if (row_blk != ROW_LAST) begin
          row_blk <= row_blk + ROW_W'(1);
        end else begin
          row_blk <= '0;
          plane   <= (plane == PLANE_V) ? PLANE_Y : plane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/block_fetch_pp.sv
// Fetches one BxB block of 16-bit samples from SRAM (Y, U, V raster order) into a DPRAM half.
// state      | meaning
// S_BF_IDLE  | waiting for BF_start; coordinates show the last fetched block
// S_BF_ISSUE | one SRAM address per cycle, k = 0..B*B-1
// S_BF_DRAIN | waiting for in-flight reads to land, then pulse BF_done
module block_fetch_pp
  import block_fetch_pp_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int BLK_LOG2 = 3,
  parameter int SRAM_LAT = 3,
  parameter int Y_BASE   = 76800,
  parameter int U_BASE   = 153600,
  parameter int V_BASE   = 192000,
  parameter int SIGN_EXT = 1
) (
  input  logic                                       CLOCK_50_I,
  input  logic                                       Resetn,
  input  logic                                       BF_start,
  input  logic                                       BF_bank,
  input  logic                                       BF_frame_restart,
  output logic                                       BF_busy,
  output logic                                       BF_done,
  output logic                                       BF_frame_done,
  output logic [1:0]                                 BF_plane,
  output logic [$clog2(IMG_H/(2**BLK_LOG2))-1:0]     BF_row_blk,
  output logic [$clog2(IMG_W/(2**BLK_LOG2))-1:0]     BF_col_blk,
  output logic [17:0]                                SRAM_address,
  input  logic [15:0]                                SRAM_read_data,
  output logic [31:0]                                BF_write_data,
  output logic [2*BLK_LOG2:0]                        BF_write_address,
  output logic                                       BF_write_enable
);

  localparam int ROW_W = $clog2(IMG_H / (2**BLK_LOG2));
  localparam int COL_W = $clog2(IMG_W / (2**BLK_LOG2));
  localparam logic [2*BLK_LOG2-1:0] K_LAST     = '1;
  localparam logic [SRAM_LAT-1:0]   LAST_STAGE = SRAM_LAT'(1 << (SRAM_LAT - 1));

  bf_state_type          state;
  logic                  bank;
  logic                  frame_flag;
  logic [2*BLK_LOG2-1:0] k;
  logic [SRAM_LAT-1:0]   pipe_v;
  logic [2*BLK_LOG2:0]   pipe_idx [SRAM_LAT];
  logic [1:0]            gen_plane;
  logic [ROW_W-1:0]      gen_row;
  logic [COL_W-1:0]      gen_col;
  logic                  last_block;
  logic                  issuing;
  logic                  advance;
  logic                  restart;
  logic                  drain_ok;

  assign issuing  = (state == S_BF_ISSUE);
  assign advance  = issuing && (k == K_LAST);
  assign restart  = (state == S_BF_IDLE) && BF_frame_restart;
  // only the stage presenting the final write may still be occupied
  assign drain_ok = (pipe_v & ~LAST_STAGE) == '0;

  bf_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .BLK_LOG2 (BLK_LOG2),
    .Y_BASE   (Y_BASE),
    .U_BASE   (U_BASE),
    .V_BASE   (V_BASE),
    .ROW_W    (ROW_W),
    .COL_W    (COL_W)
  ) u_addr_gen (
    .CLOCK_50_I   (CLOCK_50_I),
    .Resetn       (Resetn),
    .advance      (advance),
    .restart      (restart),
    .sample_idx   (k),
    .plane        (gen_plane),
    .row_blk      (gen_row),
    .col_blk      (gen_col),
    .last_block   (last_block),
    .sram_address (SRAM_address)
  );

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state         <= S_BF_IDLE;
      bank          <= 1'b0;
      frame_flag    <= 1'b0;
      k             <= '0;
      BF_busy       <= 1'b0;
      BF_done       <= 1'b0;
      BF_frame_done <= 1'b0;
      BF_plane      <= PLANE_Y;
      BF_row_blk    <= '0;
      BF_col_blk    <= '0;
    end else begin
      BF_done       <= 1'b0;
      BF_frame_done <= 1'b0;
      case (state)
        S_BF_IDLE: begin
          if (BF_start) begin
            state      <= S_BF_ISSUE;
            bank       <= BF_bank;
            frame_flag <= 1'b0;
            k          <= '0;
            BF_busy    <= 1'b1;
            BF_plane   <= BF_frame_restart ? PLANE_Y : gen_plane;
            BF_row_blk <= BF_frame_restart ? '0 : gen_row;
            BF_col_blk <= BF_frame_restart ? '0 : gen_col;
          end
        end
        S_BF_ISSUE: begin
          k <= k + (2*BLK_LOG2)'(1);
          if (k == K_LAST) begin
            frame_flag <= last_block;
            state      <= S_BF_DRAIN;
          end
        end
        S_BF_DRAIN: begin
          if (drain_ok) begin
            BF_done       <= 1'b1;
            BF_frame_done <= frame_flag;
            BF_busy       <= 1'b0;
            state         <= S_BF_IDLE;
          end
        end
        default: state <= S_BF_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= issuing;
      pipe_idx[0] <= {bank, k};
      for (int i = 1; i < SRAM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign BF_write_enable  = pipe_v[SRAM_LAT-1];
  assign BF_write_address = pipe_idx[SRAM_LAT-1];
  assign BF_write_data    = widen_sample(SRAM_read_data, SIGN_EXT != 0);

endmodule
